// File: rtl/conv_seq_pkg.sv
// Shared types and helpers for the conv frame sequencer.
package conv_seq_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DRAIN} seq_state_t;

  typedef logic [15:0] pixel_t;

  // Pixels per square frame.
  function automatic int unsigned pix_n(input int unsigned img_size);
    return img_size * img_size;
  endfunction

endpackage

// File: rtl/conv_seq_vld_delay.sv
// Read-strobe delay line matching the pixel buffer read latency.
module conv_seq_vld_delay #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vld_i,
  output logic vld_o
);

  logic [Depth-1:0] sr_q, sr_d;

  // Shift the strobe one stage per cycle.
  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = vld_i;
    for (int i = 1; i < Depth; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Shift register state, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign vld_o = sr_q[Depth-1];

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer: issues N gap-free buffer reads per frame, forwards the pixels to the
// windower and counts conv outputs for completion and protocol errors.
// Optional build macro CONV_SEQ_B2B_EN enables back-to-back frames (start accepted in DRAIN).
module conv_frame_sequencer
  import conv_seq_pkg::*;
#(
  parameter int unsigned IMG_SIZE = 32,
  parameter int unsigned CH_IN    = 3,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [ADDR_W-1:0]       frame_base_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    frame_err_o,
  output logic                    rd_en_o,
  output logic [ADDR_W-1:0]       rd_addr_o,
  input  logic [CH_IN*16-1:0]     rd_data_i,
  output logic                    conv_vld_o,
  output logic [CH_IN-1:0][15:0]  conv_in_o,
  input  logic                    conv_vld_out_i
);

  localparam int unsigned N    = pix_n(IMG_SIZE);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam int unsigned FlW  = $clog2(RD_LAT + 1);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
  localparam logic [FlW-1:0]  FlLast  = FlW'(RD_LAT);

  seq_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [IdxW-1:0]     rd_idx_q, rd_idx_d;
  logic [FlW-1:0]      fl_cnt_q, fl_cnt_d;
  logic [CntW-1:0]     out_cnt_q, out_cnt_d;
  logic                err_q, err_d;
  logic                accept, done;
  logic                vld_dly, conv_vld_q;
  pixel_t [CH_IN-1:0]  conv_in_q;
`ifdef CONV_SEQ_B2B_EN
  logic [1:0]          pend_q, pend_d;
`endif

  // Output counting, error detection and FSM next state.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    rd_idx_d  = rd_idx_q;
    fl_cnt_d  = fl_cnt_q;
    out_cnt_d = out_cnt_q;
    err_d     = err_q;
    done      = 1'b0;
    accept    = 1'b0;
`ifdef CONV_SEQ_B2B_EN
    // Counter wraps per frame; outputs with no frame in flight are errors.
    if (conv_vld_out_i) begin
      if (pend_q == 2'd0) begin
        err_d = 1'b1;
      end else if (out_cnt_q == CntLast) begin
        out_cnt_d = '0;
        done      = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + CntW'(1);
      end
    end
    accept = start_i && ((state_q == IDLE) || ((state_q == DRAIN) && (pend_q != 2'd2)));
    pend_d = pend_q + {1'b0, accept} - {1'b0, done};
`else
    // Counter saturates at N; a further output is an overrun.
    if (conv_vld_out_i) begin
      if ((state_q == IDLE) || (out_cnt_q == CntMax)) begin
        err_d = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + CntW'(1);
      end
    end
    accept = start_i && (state_q == IDLE);
    done   = (state_q == DRAIN) && (out_cnt_d == CntMax);
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          base_d    = frame_base_i;
          rd_idx_d  = '0;
          out_cnt_d = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        rd_idx_d = rd_idx_q + IdxW'(1);
        if (rd_idx_q == LastIdx) begin
          fl_cnt_d = '0;
          state_d  = FLUSH;
        end
      end
      FLUSH: begin
        // Hold off until the last read has come out of conv_vld.
        fl_cnt_d = fl_cnt_q + FlW'(1);
        if (fl_cnt_q == FlLast) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
`ifdef CONV_SEQ_B2B_EN
        if (accept) begin
          base_d   = frame_base_i;
          rd_idx_d = '0;
          state_d  = ISSUE;
        end else if (pend_d == 2'd0) begin
          state_d = IDLE;
        end
`else
        if (done) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      base_q    <= '0;
      rd_idx_q  <= '0;
      fl_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
`ifdef CONV_SEQ_B2B_EN
      pend_q    <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      rd_idx_q  <= rd_idx_d;
      fl_cnt_q  <= fl_cnt_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
`ifdef CONV_SEQ_B2B_EN
      pend_q    <= pend_d;
`endif
    end
  end

  conv_seq_vld_delay #(
    .Depth (RD_LAT)
  ) u_vld_delay (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .vld_i  (rd_en_o),
    .vld_o  (vld_dly)
  );

  // Register buffer data the cycle its read strobe emerges from the delay line.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      conv_vld_q <= 1'b0;
      conv_in_q  <= '0;
    end else begin
      conv_vld_q <= vld_dly;
      if (vld_dly) begin
        conv_in_q <= rd_data_i;
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign rd_en_o     = (state_q == ISSUE);
  assign rd_addr_o   = rd_en_o ? (base_q + ADDR_W'(rd_idx_q)) : '0;
  assign done_o      = done;
  assign frame_err_o = err_q;
  assign conv_vld_o  = conv_vld_q;
  assign conv_in_o   = conv_in_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Randomized scoreboard bench for conv_frame_sequencer.
module tb_conv_frame_sequencer;

  localparam int IMG    = 32;
  localparam int CH     = 3;
  localparam int AW     = 10;
  localparam int RD_LAT = 2;
  localparam int N      = IMG * IMG;
  localparam int DW     = CH * 16;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  start_i;
  logic [AW-1:0]         frame_base_i;
  logic                  busy_o, done_o, frame_err_o, rd_en_o, conv_vld_o;
  logic [AW-1:0]         rd_addr_o;
  logic [DW-1:0]         rd_data_i;
  logic [CH-1:0][15:0]   conv_in_o;
  logic                  conv_vld_out_i;

  conv_frame_sequencer #(
    .IMG_SIZE (IMG),
    .CH_IN    (CH),
    .ADDR_W   (AW),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .frame_base_i   (frame_base_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .frame_err_o    (frame_err_o),
    .rd_en_o        (rd_en_o),
    .rd_addr_o      (rd_addr_o),
    .rd_data_i      (rd_data_i),
    .conv_vld_o     (conv_vld_o),
    .conv_in_o      (conv_in_o),
    .conv_vld_out_i (conv_vld_out_i)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Pixel buffer model: data appears RD_LAT cycles after the read strobe.
  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] lat [RD_LAT];
  always @(posedge clk_i) begin
    lat[0] <= rd_en_o ? mem[rd_addr_o] : DW'({$urandom, $urandom});
    for (int i = 1; i < RD_LAT; i++) lat[i] <= lat[i-1];
  end
  assign rd_data_i = lat[RD_LAT-1];

  // Scoreboard queues.
  logic [AW-1:0] exp_rd[$];
  logic [DW-1:0] exp_pix[$];
  int            exp_done[$];
  int            rise_q[$];

  task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_true(input string name, input logic cond);
    checks++;
    if (cond !== 1'b1) begin
      failures++;
      $display("FAIL %s got=%b expected=1 (cycle %0d)", name, cond, cyc);
    end
  endtask

  // Monitor: pops and compares whenever the DUT presents an output.
  int rd_run = 0, vld_run = 0;
  logic busy_chk = 1'b0;
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (busy_chk) begin
        chk("busy_after_done", busy_o, 0);
        busy_chk = 1'b0;
      end
      if (rd_en_o) begin
        if (rd_run == 0) rise_q.push_back(cyc);
        rd_run++;
        expect_true("rd_expected", exp_rd.size() != 0);
        if (exp_rd.size() != 0) chk("rd_addr", rd_addr_o, exp_rd.pop_front());
      end else if (rd_run != 0) begin
        chk("rd_run_len", rd_run, N);
        rd_run = 0;
      end
      if (conv_vld_o) begin
        if (vld_run == 0) begin
          expect_true("vld_rise_expected", rise_q.size() != 0);
          if (rise_q.size() != 0) chk("vld_latency", cyc - rise_q.pop_front(), RD_LAT + 1);
        end
        vld_run++;
        expect_true("pix_expected", exp_pix.size() != 0);
        if (exp_pix.size() != 0) chk("conv_in", conv_in_o, exp_pix.pop_front());
      end else if (vld_run != 0) begin
        chk("vld_run_len", vld_run, N);
        vld_run = 0;
      end
      if (done_o) begin
        expect_true("done_expected", exp_done.size() != 0);
        if (exp_done.size() != 0) chk("done_cycle", cyc, exp_done.pop_front());
`ifndef CONV_SEQ_B2B_EN
        busy_chk = 1'b1;
`endif
      end
    end else begin
      rd_run   = 0;
      vld_run  = 0;
      busy_chk = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_frame(input logic [AW-1:0] base);
    logic [AW-1:0] a;
    tick();
    start_i      = 1'b1;
    frame_base_i = base;
    for (int i = 0; i < N; i++) begin
      a = AW'((int'(base) + i) % (1 << AW));
      exp_rd.push_back(a);
      exp_pix.push_back(mem[a]);
    end
    tick();
    start_i      = 1'b0;
    frame_base_i = AW'($urandom);
    chk("rd_en_after_start", rd_en_o, 1);
  endtask

  task automatic wait_vld();
    int k = 0;
    while (!conv_vld_o && k < 20) begin
      tick();
      k++;
    end
    expect_true("conv_vld_seen", conv_vld_o);
  endtask

  // Pipeline output model: pulses with random gaps; every N-th completes a frame.
  task automatic emit(input int n);
    for (int k = 1; k <= n; k++) begin
      int g;
      g = 0;
      tick();
      while (g < 3 && $urandom_range(0, 2) == 0) begin
        conv_vld_out_i = 1'b0;
        g++;
        tick();
      end
      conv_vld_out_i = 1'b1;
      if (k % N == 0) exp_done.push_back(cyc);
    end
    tick();
    conv_vld_out_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy_o && k < 50) begin
      tick();
      k++;
    end
    chk("idle_reached", busy_o, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    for (int i = 0; i < (1 << AW); i++) begin
      r      = {$urandom, $urandom};
      mem[i] = r[DW-1:0];
    end
    rst_ni         = 1'b0;
    start_i        = 1'b0;
    frame_base_i   = '0;
    conv_vld_out_i = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", frame_err_o, 0);
    chk("rst_rd_en", rd_en_o, 0);
    chk("rst_rd_addr", rd_addr_o, 0);
    chk("rst_conv_vld", conv_vld_o, 0);
    chk("rst_conv_in", conv_in_o, 0);
    rst_ni = 1'b1;
    tick();

    // Basic frame.
    start_frame(10'h010);
    wait_vld();
    emit(N);
    wait_idle();

    // Address wrap, then overrun error.
    start_frame(10'h3F0);
    wait_vld();
    emit(N);
    wait_idle();
    chk("err_before_overrun", frame_err_o, 0);
    tick();
    conv_vld_out_i = 1'b1;
    tick();
    conv_vld_out_i = 1'b0;
    chk("err_after_overrun", frame_err_o, 1);
    repeat (5) tick();
    chk("err_sticky", frame_err_o, 1);

    // Abort mid-issue with reset.
    start_frame(10'h100);
    repeat (499) tick();
    chk("rd_en_mid_issue", rd_en_o, 1);
    rst_ni = 1'b0;
    tick();
    exp_rd.delete();
    exp_pix.delete();
    rise_q.delete();
    rst_ni = 1'b1;
    chk("abort_busy", busy_o, 0);
    chk("abort_rd_en", rd_en_o, 0);
    chk("abort_rd_addr", rd_addr_o, 0);
    chk("abort_conv_vld", conv_vld_o, 0);
    chk("abort_conv_in", conv_in_o, 0);
    chk("abort_err", frame_err_o, 0);
    chk("abort_done", done_o, 0);
    start_frame(10'h200);
    wait_vld();
    emit(N);
    wait_idle();

    // start during ISSUE must be ignored.
    start_frame(10'h080);
    repeat (100) tick();
    start_i      = 1'b1;
    frame_base_i = 10'h300;
    tick();
    start_i = 1'b0;
    wait_vld();
    emit(N);
    wait_idle();
    repeat (10) tick();
    chk("no_restart", busy_o, 0);

`ifdef CONV_SEQ_B2B_EN
    // Back-to-back: second frame accepted in DRAIN.
    start_frame(10'h040);
    wait_vld();
    fork
      emit(2 * N);
      begin
        int k = 0;
        while (rd_en_o && k < 2000) begin
          tick();
          k++;
        end
        chk("b2b_issue_end", rd_en_o, 0);
        repeat (RD_LAT + 2) tick();
        chk("b2b_busy_in_drain", busy_o, 1);
        start_frame(10'h2C0);
      end
    join
    wait_idle();
`endif

    repeat (5) tick();
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("pix_queue_empty", exp_pix.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
